// File: rtl/trng_sampler_if.sv
// Output word channel of the TRNG sampler: a packed random word plus a
// valid/ready handshake. The sampler is the master and the consumer is the slave.
interface trng_sampler_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/trng_sampler.sv
// TRNG sampler: synchronizes N_CH asynchronous jitter sources, XOR-combines
// them into one sample per cycle, optionally removes bias with a von Neumann
// extractor, packs the bits into WIDTH-bit words and hands the words out over
// a valid/ready channel. It also monitors the combined sample for stuck runs.
module trng_sampler #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8,
    parameter int VN_EN       = 1,
    parameter int STUCK_LIMIT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] raw_in,
    trng_sampler_if.master  out_bus,
    output logic            overflow,
    output logic            stuck
);

    localparam int                 CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WIDTH);
    localparam logic [15:0]        RUN_MAX  = 16'(STUCK_LIMIT);

    typedef enum logic {
        VN_IDLE,
        VN_FIRST
    } vn_state_t;

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic             x_q;
    logic             sv_q;

    vn_state_t        state_q;
    vn_state_t        state_d;
    logic             first_q;
    logic             bit_v;
    logic             bit_d;

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic             full;
    logic             fire;

    logic [15:0]      run_q;
    logic             last_x_q;

    // Synchronizer chains: every stage clocked each cycle, independent of en.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchronizer array is reset too, so no stale entropy survives a reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Combined sample and its valid flag, registered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= 1'b0;
            sv_q <= 1'b0;
        end else begin
            x_q  <= ^sync_q[SYNC_STAGES-1];
            sv_q <= en;
        end
    end

    // Debias state register and the stored first sample of a pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VN_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sv_q && state_q == VN_IDLE) begin
                first_q <= x_q;
            end
        end
    end

    // Debias next state and emitted bit: a pair 01 gives 0, 10 gives 1, equal pairs give nothing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d = state_q;
        bit_v   = 1'b0;
        bit_d   = x_q;
        if (VN_EN != 0) begin
            if (!sv_q) begin
                state_d = VN_IDLE;
            end else if (state_q == VN_IDLE) begin
                state_d = VN_FIRST;
            end else begin
                state_d = VN_IDLE;
                bit_v   = (first_q != x_q);
                bit_d   = first_q;
            end
        end else begin
            bit_v = sv_q;
        end
    end

    assign full = (cnt_q == CNT_FULL);
    assign fire = out_bus.out_valid && out_bus.out_ready;

    // Packer next state: a full word is handed off this edge, so counting restarts from zero.
    always_comb begin
        cnt_base = full ? '0 : cnt_q;
        word_d   = word_q;
        cnt_d    = cnt_base;
        if (!sv_q) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (bit_v) begin
            word_d = {word_q[WIDTH-2:0], bit_d};
            cnt_d  = cnt_base + CNT_W'(1);
        end
    end

    // Packer shift register and bit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output register: load a completed word if the slot is free or being consumed, else drop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bus.out_data  <= '0;
            out_bus.out_valid <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            if (full) begin
                if (!out_bus.out_valid || fire) begin
                    out_bus.out_data  <= word_q;
                    out_bus.out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (fire) begin
                out_bus.out_valid <= 1'b0;
            end
        end
    end

    // Saturating run length of identical consecutive valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= '0;
            last_x_q <= 1'b0;
        end else if (sv_q) begin
            last_x_q <= x_q;
            if (run_q != '0 && x_q == last_x_q) begin
                if (run_q < RUN_MAX) begin
                    run_q <= run_q + 16'd1;
                end
            end else begin
                run_q <= 16'd1;
            end
        end
    end

    assign stuck = (run_q >= RUN_MAX);

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler. Two instances see the same sample stream:
// dut_a in raw pass-through mode (one channel) and dut_b with von Neumann
// debiasing (four channels whose XOR equals the intended sample bit).
module tb_trng_sampler;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       raw_a;
    logic [3:0] raw_b;
    logic       ovf_a;
    logic       ovf_b;
    logic       stuck_a;
    logic       stuck_b;
    logic       v_d1;
    logic       v_d2;

    int n_checks;
    int n_fail;

    trng_sampler_if #(.WIDTH(8)) bus_a ();
    trng_sampler_if #(.WIDTH(8)) bus_b ();

    trng_sampler #(
        .N_CH(1), .SYNC_STAGES(2), .WIDTH(8), .VN_EN(0), .STUCK_LIMIT(64)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_in(raw_a),
        .out_bus(bus_a), .overflow(ovf_a), .stuck(stuck_a)
    );

    trng_sampler #(
        .N_CH(4), .SYNC_STAGES(2), .WIDTH(8), .VN_EN(1), .STUCK_LIMIT(64)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .raw_in(raw_b),
        .out_bus(bus_b), .overflow(ovf_b), .stuck(stuck_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          use_vn;
        logic [31:0] samples;
        logic [31:0] vmask;
        int          n;
        logic [7:0]  exp_data;
        logic        exp_valid;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: sample bit b, counted only when v=1. en is
    // delayed two cycles so it lines up with the sample inside the DUT.
    task automatic step(input logic b, input logic v);
        logic [3:0] r;
        @(negedge clk);
        raw_a = b;
        r = 4'($urandom_range(0, 15));
        if (^r != b) r[0] = ~r[0];
        raw_b = r;
        en    = v_d2;
        v_d2  = v_d1;
        v_d1  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(b[i], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        v_d1  = 1'b0;
        v_d2  = 1'b0;
        raw_a = 1'b0;
        raw_b = 4'h0;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        raw_a = 1'b0;
        raw_b = 4'h0;
        v_d1  = 1'b0;
        v_d2  = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;

        vecs[0]  = '{1'b0, 32'hB2,    32'hFFFF_FFFF, 8,  8'hB2, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'hFF,    32'hFFFF_FFFF, 8,  8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h2D,    32'hFFFF_FFFF, 7,  8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h1234,  32'hFFFF_FFFF, 16, 8'h12, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 32'h93A6,  32'hFFFF_FFFF, 16, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h93A6A, 32'hFFFF_FFFF, 20, 8'hB7, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'hAAAA,  32'hFFFF_FFFF, 16, 8'hFF, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h5555,  32'hFFFF_FFFF, 16, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h0F0F,  32'hFFFF_FFFF, 16, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h9999,  32'hFFFF_FFFF, 16, 8'hAA, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h58C3,  32'h7CFF,      15, 8'hC3, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 32'h2AAAA, 32'h2FFFF,     18, 8'hFF, 1'b1, 1'b0};

        // Reset state of both instances.
        #3;
        check("rst data_a",  32'(bus_a.out_data),  32'h0);
        check("rst valid_a", 32'(bus_a.out_valid), 32'h0);
        check("rst ovf_a",   32'(ovf_a),           32'h0);
        check("rst stuck_a", 32'(stuck_a),         32'h0);
        check("rst valid_b", 32'(bus_b.out_valid), 32'h0);
        check("rst ovf_b",   32'(ovf_b),           32'h0);

        // Table of sample streams, each applied from reset and flushed.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            for (int i = vecs[t].n - 1; i >= 0; i--) begin
                step(vecs[t].samples[i], vecs[t].vmask[i]);
            end
            repeat (4) step(1'b0, 1'b0);
            if (vecs[t].use_vn) begin
                check($sformatf("vec%0d data", t),  32'(bus_b.out_data),  32'(vecs[t].exp_data));
                check($sformatf("vec%0d valid", t), 32'(bus_b.out_valid), 32'(vecs[t].exp_valid));
                check($sformatf("vec%0d ovf", t),   32'(ovf_b),           32'(vecs[t].exp_ovf));
            end else begin
                check($sformatf("vec%0d data", t),  32'(bus_a.out_data),  32'(vecs[t].exp_data));
                check($sformatf("vec%0d valid", t), 32'(bus_a.out_valid), 32'(vecs[t].exp_valid));
                check($sformatf("vec%0d ovf", t),   32'(ovf_a),           32'(vecs[t].exp_ovf));
            end
        end

        // Pass-through latency: bits on edges 1..8, word visible after edge 12.
        do_reset();
        feed_byte(8'hB2);
        repeat (3) step(1'b0, 1'b0);
        check("lat valid e11", 32'(bus_a.out_valid), 32'h0);
        step(1'b0, 1'b0);
        check("lat valid e12", 32'(bus_a.out_valid), 32'h1);
        check("lat data e12",  32'(bus_a.out_data),  32'hB2);

        // Two words with no consumer: second is dropped, first is held.
        do_reset();
        feed_byte(8'hC5);
        feed_byte(8'h3A);
        repeat (3) step(1'b0, 1'b0);
        check("hs first valid", 32'(bus_a.out_valid), 32'h1);
        check("hs first data",  32'(bus_a.out_data),  32'hC5);
        check("hs first ovf",   32'(ovf_a),           32'h0);
        step(1'b0, 1'b0);
        check("hs drop ovf",    32'(ovf_a),           32'h1);
        check("hs drop data",   32'(bus_a.out_data),  32'hC5);
        bus_a.out_ready = 1'b1;
        step(1'b0, 1'b0);
        bus_a.out_ready = 1'b0;
        check("hs take valid",  32'(bus_a.out_valid), 32'h0);
        check("hs ovf sticky",  32'(ovf_a),           32'h1);

        // Handshake on the same edge the next word completes.
        do_reset();
        feed_byte(8'hC5);
        feed_byte(8'h3A);
        repeat (3) step(1'b0, 1'b0);
        bus_a.out_ready = 1'b1;
        step(1'b0, 1'b0);
        bus_a.out_ready = 1'b0;
        check("sim valid", 32'(bus_a.out_valid), 32'h1);
        check("sim data",  32'(bus_a.out_data),  32'h3A);
        check("sim ovf",   32'(ovf_a),           32'h0);
        step(1'b0, 1'b0);
        check("sim hold data", 32'(bus_a.out_data), 32'h3A);

        // Stuck detection: 64 ones after two zeros, then a zero.
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            step((k >= 3 && k <= 66) ? 1'b1 : 1'b0, 1'b1);
            if (k == 68) check("stuck run63", 32'(stuck_a), 32'h0);
            if (k == 69) check("stuck run64", 32'(stuck_a), 32'h1);
            if (k == 70) check("stuck clear", 32'(stuck_a), 32'h0);
        end

        // Asynchronous reset with a word pending and five bits of the next one.
        do_reset();
        feed_byte(8'hE1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("mid valid before", 32'(bus_a.out_valid), 32'h1);
        check("mid data before",  32'(bus_a.out_data),  32'hE1);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        v_d1  = 1'b0;
        v_d2  = 1'b0;
        #1;
        check("mid rst data",  32'(bus_a.out_data),  32'h0);
        check("mid rst valid", 32'(bus_a.out_valid), 32'h0);
        check("mid rst ovf",   32'(ovf_a),           32'h0);
        check("mid rst stuck", 32'(stuck_a),         32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        feed_byte(8'h6D);
        repeat (4) step(1'b0, 1'b0);
        check("mid fresh valid", 32'(bus_a.out_valid), 32'h1);
        check("mid fresh data",  32'(bus_a.out_data),  32'h6D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_sampler.md
TRNG_SAMPLER -- requirements
Module: trng_sampler

Interface
REQ-001 Parameter N_CH, default 4, is the number of asynchronous entropy inputs (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer flop depth per channel (>=2).
REQ-003 Parameter WIDTH, default 8, is the output word width (2..32).
REQ-004 Parameter VN_EN, default 1, selects the mode: 1 = von Neumann debiasing, 0 = raw pass-through.
REQ-005 Parameter STUCK_LIMIT, default 64, is the run length at which the stuck flag asserts (2..65535).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 en  input  1  sample enable.
REQ-009 raw_in  input  N_CH  asynchronous ring-oscillator / jitter sources.
REQ-010 out_data  output  WIDTH  packed random word.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 overflow  output  1  sticky flag: a completed word was dropped.
REQ-014 stuck  output  1  combined sample has been constant for >= STUCK_LIMIT samples.

Function
REQ-015 Each raw_in bit passes through SYNC_STAGES flops in series, clocked every cycle regardless of en.
REQ-016 Combined sample x is the registered XOR-reduce of the synchronizer outputs.
REQ-017 Sample-valid sv is en, registered on the same edge as x.
REQ-018 Latency: raw_in sampled at edge E enters the debias/packer stage at edge E+SYNC_STAGES+1.
REQ-019 VN_EN=0: every sample with sv=1 is one packer input bit.
REQ-020 VN_EN=1 state machine: IDLE -> FIRST on sv (store x); FIRST -> IDLE on sv.
REQ-021 FIRST->IDLE pair handling: 01 emits 0, 10 emits 1, 00/11 emit nothing.
REQ-022 Packer shifts each input bit into the LSB: word <= {word[WIDTH-2:0], bit}; bit count increments.
REQ-023 On the WIDTH-th bit, the next edge loads out_data with word, sets out_valid=1 and clears the count.
REQ-024 out_valid and out_data are held stable until the edge where out_valid && out_ready; out_valid then clears.
REQ-025 The packer keeps filling while out_valid=1.
REQ-026 Word completes while out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged and overflow is set.
REQ-027 Word completes on the same edge as a handshake: the new word is loaded and out_valid stays 1.
REQ-028 en=0 (sv=0): the VN FSM returns to IDLE, the partial word and bit count clear, and the output register and handshake are unaffected.
REQ-029 Stuck counter: saturating run length of equal consecutive x while sv=1.
REQ-030 Stuck counter update: it resets to 1 on a changed x value.
REQ-031 stuck is 1 while the run length is >= STUCK_LIMIT and clears one cycle after a differing sample.

Reset
REQ-032 rst_n=0 immediately clears all synchronizer flops, x, sv, VN state (IDLE), word, count, out_data, out_valid, overflow, stuck and the run counter.
REQ-033 Reset mid-word discards the partial word; after release the first word uses only post-reset bits.
REQ-034 overflow clears only by reset.

Verification
REQ-035 Pass-through (N_CH=1, SYNC_STAGES=2, WIDTH=8, VN_EN=0, en=1), raw_in=1,0,1,1,0,0,1,0 on edges 1..8 -> out_valid rises after edge 12, out_data=8'hB2.
REQ-036 VN_EN=1: sixteen samples forming pairs 10,01,00,11,10,10,01,10 -> emits 1,0,1,1,0,1; no word yet; two further 10 pairs -> out_data=8'hB7.
REQ-037 Handshake: out_ready=0 for two completed words -> overflow=1 and out_data holds the first word; then out_ready=1 for one cycle -> out_valid=0.
REQ-038 Simultaneous handshake and completion -> out_valid stays 1, out_data holds the new word, overflow=0.
REQ-039 x held at 1 for 64 samples (STUCK_LIMIT=64) -> stuck=1; then one x=0 sample -> stuck=0 on the next cycle.
REQ-040 rst_n pulsed low after 5 bits of a word -> all outputs 0 asynchronously; the next word is formed from 8 fresh bits only.
